// File: rtl/checkpoint_seq_pkg.sv
// Shared types and constants for the ordered-checkpoint monitor.
package checkpoint_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_TMO  = 2'b01;
    localparam logic [1:0] FC_OOO  = 2'b10;
    localparam logic [1:0] FC_CFG  = 2'b11;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chk_stable_filter.sv
// Glitch filter: o_qual pulses when i_match has held for STABLE_CYC cycles,
// then the count restarts so a held value must re-qualify.
module chk_stable_filter #(
    parameter int STABLE_CYC = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic i_match,
    input  logic i_clr,
    output logic o_qual
);

    localparam int            CW   = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_cnt;

    assign o_qual = i_match & ~i_clr & (r_cnt == LAST);

    // Consecutive-match counter.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_cnt <= '0;
        end else if (i_clr || !i_match || o_qual) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + ONE;
        end
    end

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Ordered-checkpoint monitor for the checkbits bus: programmable value/mask list,
// glitch filtering, per-checkpoint timeout and optional strict ordering.
module checkpoint_seq_monitor
    import checkpoint_seq_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_CHK    = 8,
    parameter int STABLE_CYC = 2,
    parameter int TMO_W      = 24
) (
    input  logic                       clock,
    input  logic                       resetb,
    input  logic [WIDTH-1:0]           obs_bus,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_CHK)-1:0] cfg_idx,
    input  logic [WIDTH-1:0]           cfg_value,
    input  logic [WIDTH-1:0]           cfg_mask,
    input  logic [$clog2(NUM_CHK):0]   cfg_num,
    input  logic [TMO_W-1:0]           cfg_timeout,
    input  logic                       strict,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [$clog2(NUM_CHK)-1:0] cur_idx,
    output logic                       hit,
    output logic [$clog2(NUM_CHK)-1:0] hit_idx
);

    localparam int             IW      = idx_w(NUM_CHK);
    localparam int             CNW     = IW + 1;
    localparam logic [IW-1:0]  IDX_ONE = IW'(1);
    localparam logic [CNW-1:0] NUM_ONE = CNW'(1);
    localparam logic [CNW-1:0] NUM_MAX = CNW'(NUM_CHK);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

    logic [WIDTH-1:0] r_value [NUM_CHK];
    logic [WIDTH-1:0] r_mask  [NUM_CHK];
    logic [WIDTH-1:0] r_bus_q;
    state_e           r_state;
    logic [IW-1:0]    r_cur_idx;
    logic [IW-1:0]    r_hit_idx;
    logic [TMO_W-1:0] r_tmo;
    logic [1:0]       r_fail_code;
    logic             r_busy;
    logic             r_pass;
    logic             r_fail;
    logic             r_hit;

    state_e           w_state_nxt;
    logic [IW-1:0]    w_cur_nxt;
    logic [IW-1:0]    w_hit_idx_nxt;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic [TMO_W-1:0] w_tmo_inc;
    logic [1:0]       w_code_nxt;
    logic             w_pass_nxt;
    logic             w_fail_nxt;
    logic             w_hit_nxt;
    logic             w_tracking;
    logic             w_match_cur;
    logic             w_accept;
    logic             w_is_last;
    logic             w_cfg_bad;
    logic             w_ooo;
    logic             w_tmo_hit;
    logic             w_clr_look;
    logic [NUM_CHK-1:0] w_look_match;
    logic [NUM_CHK-1:0] w_look_qual;

    assign w_tracking  = (r_state == ST_TRACK);
    assign w_match_cur = (((r_bus_q ^ r_value[r_cur_idx]) & r_mask[r_cur_idx]) == '0);
    assign w_is_last   = ({1'b0, r_cur_idx} == (cfg_num - NUM_ONE));
    assign w_cfg_bad   = (cfg_num == '0) || (cfg_num > NUM_MAX);
    assign w_tmo_inc   = r_tmo + TMO_ONE;
    assign w_tmo_hit   = (cfg_timeout != '0) && (w_tmo_inc == cfg_timeout);
    assign w_clr_look  = ~w_tracking | w_accept;
    assign w_ooo       = strict & (|w_look_qual);

    chk_stable_filter #(.STABLE_CYC(STABLE_CYC)) u_cur_filter (
        .clock   (clock),
        .resetb  (resetb),
        .i_match (w_match_cur),
        .i_clr   (~w_tracking),
        .o_qual  (w_accept)
    );

    // Lookahead filters only count entries beyond the awaited one, and only
    // while the awaited entry itself does not match (current entry wins).
    genvar g;
    generate
        for (g = 0; g < NUM_CHK; g++) begin : g_look
            assign w_look_match[g] = (((r_bus_q ^ r_value[g]) & r_mask[g]) == '0)
                                     & (IW'(g) > r_cur_idx)
                                     & (CNW'(g) < cfg_num)
                                     & ~w_match_cur;

            chk_stable_filter #(.STABLE_CYC(STABLE_CYC)) u_look_filter (
                .clock   (clock),
                .resetb  (resetb),
                .i_match (w_look_match[g]),
                .i_clr   (w_clr_look),
                .o_qual  (w_look_qual[g])
            );
        end
    endgenerate

    // Next-state and result decode; abort overrides everything.
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur_idx;
        w_pass_nxt    = r_pass;
        w_fail_nxt    = r_fail;
        w_code_nxt    = r_fail_code;
        w_hit_nxt     = 1'b0;
        w_hit_idx_nxt = r_hit_idx;
        w_tmo_nxt     = r_tmo;
        case (r_state)
            ST_TRACK: begin
                if (w_accept) begin
                    w_hit_nxt     = 1'b1;
                    w_hit_idx_nxt = r_cur_idx;
                    w_tmo_nxt     = '0;
                    if (w_is_last) begin
                        w_state_nxt = ST_PASS;
                        w_pass_nxt  = 1'b1;
                    end else begin
                        w_cur_nxt = r_cur_idx + IDX_ONE;
                    end
                end else if (w_ooo) begin
                    w_state_nxt = ST_FAIL;
                    w_fail_nxt  = 1'b1;
                    w_code_nxt  = FC_OOO;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_FAIL;
                    w_fail_nxt  = 1'b1;
                    w_code_nxt  = FC_TMO;
                    w_tmo_nxt   = w_tmo_inc;
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                end
            end
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    w_pass_nxt = 1'b0;
                    w_cur_nxt  = '0;
                    w_tmo_nxt  = '0;
                    if (w_cfg_bad) begin
                        w_state_nxt = ST_FAIL;
                        w_fail_nxt  = 1'b1;
                        w_code_nxt  = FC_CFG;
                    end else begin
                        w_state_nxt = ST_TRACK;
                        w_fail_nxt  = 1'b0;
                        w_code_nxt  = FC_NONE;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_pass_nxt  = 1'b0;
            w_fail_nxt  = 1'b0;
            w_code_nxt  = FC_NONE;
            w_cur_nxt   = '0;
            w_hit_nxt   = 1'b0;
            w_tmo_nxt   = '0;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Control and result registers.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_bus_q     <= '0;
            r_state     <= ST_IDLE;
            r_cur_idx   <= '0;
            r_hit_idx   <= '0;
            r_tmo       <= '0;
            r_fail_code <= FC_NONE;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_hit       <= 1'b0;
        end else begin
            r_bus_q     <= obs_bus;
            r_state     <= w_state_nxt;
            r_cur_idx   <= w_cur_nxt;
            r_hit_idx   <= w_hit_idx_nxt;
            r_tmo       <= w_tmo_nxt;
            r_fail_code <= w_code_nxt;
            r_busy      <= (w_state_nxt == ST_TRACK);
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
            r_hit       <= w_hit_nxt;
        end
    end

    // Checkpoint table; frozen while a sequence is being tracked.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                r_value[i] <= '0;
                r_mask[i]  <= '0;
            end
        end else if (cfg_we && !w_tracking) begin
            r_value[cfg_idx] <= cfg_value;
            r_mask[cfg_idx]  <= cfg_mask;
        end
    end

    assign busy      = r_busy;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign fail_code = r_fail_code;
    assign cur_idx   = r_cur_idx;
    assign hit       = r_hit;
    assign hit_idx   = r_hit_idx;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Self-checking bench: table-driven happy path plus hand-written corner sequences,
// with a hit scoreboard fed by the stimulus and drained by the hit monitor.
module tb_checkpoint_seq_monitor;

    localparam int WIDTH      = 16;
    localparam int NUM_CHK    = 8;
    localparam int STABLE_CYC = 2;
    localparam int TMO_W      = 24;

    logic              clock = 1'b0;
    logic              resetb;
    logic [WIDTH-1:0]  obs_bus;
    logic              cfg_we;
    logic [2:0]        cfg_idx;
    logic [WIDTH-1:0]  cfg_value;
    logic [WIDTH-1:0]  cfg_mask;
    logic [3:0]        cfg_num;
    logic [TMO_W-1:0]  cfg_timeout;
    logic              strict;
    logic              start;
    logic              abort;
    logic              busy;
    logic              pass;
    logic              fail;
    logic [1:0]        fail_code;
    logic [2:0]        cur_idx;
    logic              hit;
    logic [2:0]        hit_idx;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mon_exp;

    typedef struct {
        logic [15:0] bus;
        int          hold;
        int          exp_hit;
        logic        exp_busy;
        logic        exp_pass;
        logic [2:0]  exp_cur;
    } vec_t;

    vec_t        vecs[12];
    logic [15:0] hv[6];

    checkpoint_seq_monitor #(
        .WIDTH(WIDTH), .NUM_CHK(NUM_CHK), .STABLE_CYC(STABLE_CYC), .TMO_W(TMO_W)
    ) dut (
        .clock(clock), .resetb(resetb), .obs_bus(obs_bus),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value), .cfg_mask(cfg_mask),
        .cfg_num(cfg_num), .cfg_timeout(cfg_timeout), .strict(strict),
        .start(start), .abort(abort),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .cur_idx(cur_idx), .hit(hit), .hit_idx(hit_idx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load(input logic [2:0] idx, input logic [15:0] val, input logic [15:0] msk);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_value = val;
        cfg_mask  = msk;
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic e_busy, input logic e_pass,
                             input logic e_fail, input logic [1:0] e_code, input logic [2:0] e_cur);
        chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
        chk({tag, "_pass"}, 32'(pass), 32'(e_pass));
        chk({tag, "_fail"}, 32'(fail), 32'(e_fail));
        chk({tag, "_code"}, 32'(fail_code), 32'(e_code));
        chk({tag, "_cur"},  32'(cur_idx), 32'(e_cur));
    endtask

    // Scoreboard drain: every hit pulse must match the next expected index.
    always @(negedge clock) begin
        if (resetb === 1'b1 && hit === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_hit", 32'(hit_idx), 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("hit_idx", 32'(hit_idx), 32'(mon_exp));
            end
        end
    end

    initial begin
        hv[0] = 16'hAB40; hv[1] = 16'h0028; hv[2] = 16'h0CA1;
        hv[3] = 16'h1787; hv[4] = 16'h2371; hv[5] = 16'hAB51;
        for (int i = 0; i < 6; i++) begin
            vecs[2*i]   = '{hv[i], 10, i, (i != 5), (i == 5), (i == 5) ? 3'd5 : 3'(i + 1)};
            vecs[2*i+1] = '{16'h0000, 3, -1, (i != 5), (i == 5), (i == 5) ? 3'd5 : 3'(i + 1)};
        end

        resetb = 1'b0; obs_bus = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_value = '0;
        cfg_mask = '0; cfg_num = '0; cfg_timeout = '0; strict = 1'b0;
        start = 1'b0; abort = 1'b0;
        tick(3);
        chk_state("reset", 1'b0, 1'b0, 1'b0, 2'b00, 3'd0);
        chk("reset_hit", 32'(hit), 32'd0);
        chk("reset_hit_idx", 32'(hit_idx), 32'd0);
        resetb = 1'b1;
        tick(1);

        // Happy path.
        for (int i = 0; i < 6; i++) load(3'(i), hv[i], 16'hFFFF);
        cfg_num = 4'd6; cfg_timeout = 24'd50000;
        pulse_start();
        chk_state("happy_start", 1'b1, 1'b0, 1'b0, 2'b00, 3'd0);
        for (int i = 0; i < 12; i++) begin
            obs_bus = vecs[i].bus;
            if (vecs[i].exp_hit >= 0) exp_q.push_back(vecs[i].exp_hit);
            tick(vecs[i].hold);
            chk_state($sformatf("happy%0d", i), vecs[i].exp_busy, vecs[i].exp_pass,
                      1'b0, 2'b00, vecs[i].exp_cur);
        end

        // Glitch filter and exact latency.
        pulse_start();
        obs_bus = 16'hAB40; tick(1);
        obs_bus = 16'h0000; tick(5);
        chk_state("glitch", 1'b1, 1'b0, 1'b0, 2'b00, 3'd0);
        obs_bus = 16'hAB40; exp_q.push_back(0);
        tick(2);
        chk("lat_early_hit", 32'(hit), 32'd0);
        obs_bus = 16'h0000;
        tick(1);
        chk("lat_hit", 32'(hit), 32'd1);
        chk("lat_hit_idx", 32'(hit_idx), 32'd0);
        tick(1);
        chk("lat_hit_one_cycle", 32'(hit), 32'd0);
        obs_bus = 16'h0028; exp_q.push_back(1);
        tick(10);
        chk("pre_abort_cur", 32'(cur_idx), 32'd2);
        pulse_abort();
        chk_state("abort", 1'b0, 1'b0, 1'b0, 2'b00, 3'd0);
        pulse_start();
        chk("restart_busy", 32'(busy), 32'd1);
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        chk("abort_wins_busy", 32'(busy), 32'd0);

        // Timeout 100 cycles after the first hit.
        cfg_num = 4'd3; cfg_timeout = 24'd100;
        obs_bus = 16'h0000;
        pulse_start();
        obs_bus = 16'hAB40; exp_q.push_back(0);
        tick(3);
        chk("tmo_hit0", 32'(hit), 32'd1);
        obs_bus = 16'h0000;
        tick(99);
        chk("tmo_early_fail", 32'(fail), 32'd0);
        tick(1);
        chk_state("tmo", 1'b0, 1'b0, 1'b1, 2'b01, 3'd1);

        // Strict ordering violation.
        cfg_timeout = '0; strict = 1'b1;
        pulse_start();
        chk_state("strict_start", 1'b1, 1'b0, 1'b0, 2'b00, 3'd0);
        obs_bus = 16'hAB40; exp_q.push_back(0);
        tick(3);
        obs_bus = 16'h0CA1;
        tick(2);
        chk("ooo_early_fail", 32'(fail), 32'd0);
        tick(1);
        chk_state("ooo", 1'b0, 1'b0, 1'b1, 2'b10, 3'd1);

        // Same stimulus without strict keeps tracking.
        strict = 1'b0;
        obs_bus = 16'h0000;
        pulse_start();
        obs_bus = 16'hAB40; exp_q.push_back(0);
        tick(3);
        obs_bus = 16'h0CA1;
        tick(10);
        chk_state("nonstrict", 1'b1, 1'b0, 1'b0, 2'b00, 3'd1);
        pulse_abort();

        // Partial mask; table write during TRACK must be ignored.
        obs_bus = 16'h0000;
        load(3'd0, 16'h0040, 16'h00FF);
        cfg_num = 4'd1;
        pulse_start();
        load(3'd0, 16'h1234, 16'hFFFF);
        obs_bus = 16'hAB40; exp_q.push_back(0);
        tick(4);
        chk_state("mask", 1'b0, 1'b1, 1'b0, 2'b00, 3'd0);

        // Config boundaries.
        cfg_num = 4'd9;
        pulse_start();
        chk_state("cfg9", 1'b0, 1'b0, 1'b1, 2'b11, 3'd0);
        pulse_abort();
        chk("cfg_abort_fail", 32'(fail), 32'd0);
        cfg_num = 4'd0;
        pulse_start();
        chk_state("cfg0", 1'b0, 1'b0, 1'b1, 2'b11, 3'd0);
        cfg_num = 4'd8; obs_bus = 16'h0000;
        pulse_start();
        chk("cfg8_busy", 32'(busy), 32'd1);
        pulse_abort();

        // Asynchronous reset mid-TRACK clears the table.
        cfg_num = 4'd3;
        pulse_start();
        tick(5);
        chk("prereset_busy", 32'(busy), 32'd1);
        #2 resetb = 1'b0;
        #1;
        chk_state("async_reset", 1'b0, 1'b0, 1'b0, 2'b00, 3'd0);
        tick(1);
        resetb = 1'b1;
        obs_bus = 16'h5A5A; cfg_num = 4'd1;
        tick(2);
        exp_q.push_back(0);
        pulse_start();
        tick(2);
        chk("cleared_mask_hit", 32'(hit), 32'd1);
        chk("cleared_mask_pass", 32'(pass), 32'd1);

        tick(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
